// File: rtl/mem_access_unit.sv
// Memory-access stage: one lw/sw per transaction against a 2**AW-word synchronous
// data memory, with a registered response returned over a valid/ready handshake.
module mem_access_unit #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_is_store,
  input  logic [DW-1:0] req_base,
  input  logic [15:0]   req_offset,
  input  logic [DW-1:0] req_wdata,
  input  logic [4:0]    req_rd,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_is_store,
  output logic [DW-1:0] resp_rdata,
  output logic [4:0]    resp_rd,
  output logic          resp_err
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic          is_store;
    logic [DW-1:0] ea;
    logic [DW-1:0] wdata;
    logic [4:0]    rd;
  } req_t;

  state_t        state, state_n;
  req_t          req_q;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] ea;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          accept;

  // Word-indexed effective address, wraps modulo 2**DW.
  assign ea       = req_base + {{(DW-16){req_offset[15]}}, req_offset};
  assign in_range = (req_q.ea[DW-1:AW] == '0);
  assign idx      = req_q.ea[AW-1:0];
  assign accept   = req_valid & req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = ACCESS;
      end
      ACCESS: state_n = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Response fields only change in ACCESS, so they hold steady through RESP backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q         <= '0;
      resp_is_store <= 1'b0;
      resp_rdata    <= '0;
      resp_rd       <= '0;
      resp_err      <= 1'b0;
    end else begin
      if (accept)
        req_q <= '{is_store: req_is_store, ea: ea, wdata: req_wdata, rd: req_rd};
      if (state == ACCESS) begin
        resp_is_store <= req_q.is_store;
        resp_rd       <= req_q.rd;
        resp_err      <= ~in_range;
        resp_rdata    <= (in_range && !req_q.is_store) ? mem[idx] : '0;
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (state == ACCESS && req_q.is_store && in_range)
      mem[idx] <= req_q.wdata;
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model checked every cycle, plus
// directed literal checks and randomized traffic with random backpressure.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, req_is_store;
  logic [31:0] req_base, req_wdata;
  logic [15:0] req_offset;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready, resp_is_store, resp_err;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit rand_bp = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_access_unit #(.AW(8), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_is_store(resp_is_store),
    .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_err(resp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a word array plus "where is the one outstanding transaction".
  logic [31:0] mmem [256];
  int          phase = 0;   // 0 free, 1 in its access cycle, 2 response offered
  logic        exp_st, exp_err;
  logic [31:0] exp_rdata;
  logic [4:0]  exp_rd;

  always @(negedge clk) begin
    logic [31:0] m_ea;
    if (rst) phase = 0;
    else begin
      chk("req_ready", 32'(req_ready), 32'(phase == 0));
      chk("resp_valid", 32'(resp_valid), 32'(phase == 2));
      if (phase == 2) begin
        chk("resp_is_store", 32'(resp_is_store), 32'(exp_st));
        chk("resp_rd", 32'(resp_rd), 32'(exp_rd));
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("resp_rdata", resp_rdata, exp_rdata);
      end
      case (phase)
        0: if (req_valid) begin
          m_ea    = req_base + 32'($signed(req_offset));
          exp_st  = req_is_store;
          exp_rd  = req_rd;
          exp_err = (m_ea >= 32'd256);
          if (req_is_store) begin
            exp_rdata = 32'd0;
            if (!exp_err) mmem[m_ea[7:0]] = req_wdata;
          end else begin
            exp_rdata = exp_err ? 32'd0 : mmem[m_ea[7:0]];
          end
          phase = 1;
        end
        1: phase = 2;
        2: if (resp_ready) phase = 0;
        default: phase = 0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1 resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1 with the unit idle; returns at posedge+1 after the handshake edge.
  task automatic xact(input bit st, input logic [31:0] base, input logic [15:0] off,
                      input logic [31:0] wd, input logic [4:0] rd,
                      output logic [31:0] rdata, output logic [4:0] rrd,
                      output logic rerr, output int acc_cyc);
    bit ok;
    int first;
    req_valid = 1'b1; req_is_store = st; req_base = base;
    req_offset = off; req_wdata = wd; req_rd = rd;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!ok) begin tests++; fails++; $display("FAIL accept_timeout: req_ready never 1"); end
    ok = 1'b0; first = -1; rdata = '0; rrd = '0; rerr = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (resp_valid && first < 0) first = cyc;
      if (resp_valid && resp_ready) begin
        ok = 1'b1; rdata = resp_rdata; rrd = resp_rd; rerr = resp_err;
        break;
      end
    end
    if (!ok) begin tests++; fails++; $display("FAIL resp_timeout: no handshake in 100 cycles"); end
    else chk("latency", 32'(first - acc_cyc), 32'd2);
    @(posedge clk); #1;
  endtask

  logic [31:0] rd_d;
  logic [4:0]  rd_t;
  logic        rd_e;
  int          ac, ac_prev;
  logic [31:0] vals [4];

  initial begin
    req_valid = 1'b0; req_is_store = 1'b0; req_base = '0; req_offset = '0;
    req_wdata = '0; req_rd = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_rd", 32'(resp_rd), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_is_store", 32'(resp_is_store), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Give every word a known value.
    for (int i = 0; i < 256; i++) xact(1'b1, 32'(i), 16'h0, $urandom, 5'd0, rd_d, rd_t, rd_e, ac);

    xact(1'b1, 32'h10, 16'h0004, 32'hDEADBEEF, 5'd0, rd_d, rd_t, rd_e, ac);
    xact(1'b0, 32'h14, 16'h0000, 32'h0, 5'd3, rd_d, rd_t, rd_e, ac);
    chk("raw_data", rd_d, 32'hDEADBEEF);
    chk("raw_rd", 32'(rd_t), 32'd3);
    chk("raw_err", 32'(rd_e), 32'd0);

    xact(1'b1, 32'h20, 16'hFFF0, 32'h12345678, 5'd0, rd_d, rd_t, rd_e, ac);
    xact(1'b0, 32'h10, 16'h0000, 32'h0, 5'd4, rd_d, rd_t, rd_e, ac);
    chk("negoff_data", rd_d, 32'h12345678);
    xact(1'b0, 32'h8010, 16'h8000, 32'h0, 5'd5, rd_d, rd_t, rd_e, ac);
    chk("off8000_data", rd_d, 32'h12345678);

    xact(1'b0, 32'h100, 16'h0000, 32'h0, 5'd6, rd_d, rd_t, rd_e, ac);
    chk("oor_err", 32'(rd_e), 32'd1);
    chk("oor_data", rd_d, 32'd0);

    xact(1'b1, 32'hFF, 16'h0000, 32'hA5A50FF0, 5'd0, rd_d, rd_t, rd_e, ac);
    xact(1'b0, 32'hFFFFFFFF, 16'h0100, 32'h0, 5'd7, rd_d, rd_t, rd_e, ac);
    chk("wrap_top_data", rd_d, 32'hA5A50FF0);
    chk("wrap_top_err", 32'(rd_e), 32'd0);

    xact(1'b1, 32'h0, 16'h0000, 32'h0BADF00D, 5'd0, rd_d, rd_t, rd_e, ac);
    xact(1'b1, 32'h100, 16'h0000, 32'h11111111, 5'd0, rd_d, rd_t, rd_e, ac);
    chk("oor_store_err", 32'(rd_e), 32'd1);
    xact(1'b0, 32'hFFFFFFFF, 16'h0001, 32'h0, 5'd8, rd_d, rd_t, rd_e, ac);
    chk("wrap_zero_data", rd_d, 32'h0BADF00D);
    chk("wrap_zero_err", 32'(rd_e), 32'd0);

    // Backpressure: response held for 5 cycles, a request pulse in that window is dropped.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_is_store = 1'b0; req_base = 32'hFF; req_offset = '0; req_rd = 5'd7;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_data", resp_rdata, 32'hA5A50FF0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      if (i == 1) begin
        req_valid = 1'b1; req_is_store = 1'b1; req_base = '0; req_wdata = 32'hFFFFFFFF;
      end else if (i == 2) req_valid = 1'b0;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    chk("bp_idle_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    xact(1'b0, 32'h0, 16'h0000, 32'h0, 5'd1, rd_d, rd_t, rd_e, ac);
    chk("dropped_req", rd_d, 32'h0BADF00D);

    // Back-to-back: 4 stores then 4 loads to words 0..3.
    vals[0] = 32'h01020304; vals[1] = 32'hCAFEF00D; vals[2] = 32'h80000001; vals[3] = 32'h7FFFFFFE;
    ac_prev = -1;
    for (int i = 0; i < 8; i++) begin
      xact(i < 4, 32'(i % 4), 16'h0, vals[i % 4], 5'(i), rd_d, rd_t, rd_e, ac);
      if (ac_prev >= 0) chk("b2b_spacing", 32'(ac - ac_prev), 32'd3);
      if (i >= 4) chk("b2b_data", rd_d, vals[i - 4]);
      ac_prev = ac;
    end

    // Asynchronous reset during a load's response.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_is_store = 1'b0; req_base = 32'h14; req_offset = '0; req_rd = 5'd9;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", 32'(resp_valid), 32'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(resp_valid), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_rdata", resp_rdata, 32'd0);
    chk("arst_rd", 32'(resp_rd), 32'd0);
    chk("arst_err", 32'(resp_err), 32'd0);
    @(posedge clk); #2 rst = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    xact(1'b0, 32'h14, 16'h0000, 32'h0, 5'd9, rd_d, rd_t, rd_e, ac);
    chk("post_rst_data", rd_d, 32'hDEADBEEF);
    chk("post_rst_rd", 32'(rd_t), 32'd9);

    // Randomized traffic with random backpressure; the per-cycle model does the checking.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] b;
      logic [15:0] o;
      int r;
      r = $urandom_range(0, 9);
      b = (r == 0) ? $urandom : 32'($urandom_range(0, 400));
      o = (r == 1) ? 16'($urandom) : 16'($urandom_range(0, 64)) - 16'd32;
      xact(1'($urandom_range(0, 1)), b, o, $urandom, 5'($urandom), rd_d, rd_t, rd_e, ac);
    end
    rand_bp = 1'b0;
    @(posedge clk); #2 resp_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
